// File: rtl/synch_req_unit.sv
// rtl/synch_req_unit.sv - core-side atomic op initiator for the sync register bank
module synch_req_unit #(
    parameter int          DEPTH     = 512,
    parameter logic [3:0]  CORE_ID   = 4'h0,
    parameter logic [35:0] SYNC_BASE = 36'h0_0000_0000,
    parameter int          TIMEOUT   = 256,
    parameter int          MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_valid,
    output logic             core_ready,
    input  logic [1:0]       core_op,
    input  logic [1:0]       core_idx,
    input  logic [31:0]      core_wdata,
    input  logic [14:0]      core_addend,
    output logic             core_resp_valid,
    output logic [31:0]      core_resp_data,
    output logic             core_resp_err,
    output logic             req_valid_out,
    input  logic             req_ready_in,
    output logic [35:0]      addr_req_out,
    output logic [DEPTH-1:0] data_req_out,
    output logic [3:0]       id_req_out,
    output logic [2:0]       packet_type_req_out,
    input  logic             resp_valid_in,
    input  logic [3:0]       id_resp_in,
    input  logic [2:0]       packet_type_resp_in,
    input  logic [DEPTH-1:0] data_resp_in
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FADD  = 2'b10;

    localparam logic [2:0] PT_WRITE = 3'b111;
    localparam logic [2:0] PT_FADD  = 3'b010;
    localparam logic [2:0] PT_READ  = 3'b100;
    localparam logic [2:0] PT_ACK   = 3'b101;
    localparam logic [2:0] PT_RDATA = 3'b110;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    // S_ERR delays the error pulse of an illegal op by one cycle so it lands
    // two cycles after the accepting cycle.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR, S_RESP} state_t;

    state_t        state;
    logic [1:0]    op_q;
    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] retry_cnt;
    logic          match;
    logic          unused_resp_bits;

    assign match = resp_valid_in && (id_resp_in == CORE_ID) &&
                   (packet_type_resp_in == ((op_q == OP_READ) ? PT_RDATA : PT_ACK));
    assign unused_resp_bits = ^data_resp_in[DEPTH-1:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            op_q                <= 2'b00;
            tmo_cnt             <= '0;
            retry_cnt           <= '0;
            core_ready          <= 1'b0;
            core_resp_valid     <= 1'b0;
            core_resp_data      <= 32'h0;
            core_resp_err       <= 1'b0;
            req_valid_out       <= 1'b0;
            addr_req_out        <= 36'h0;
            data_req_out        <= '0;
            id_req_out          <= 4'h0;
            packet_type_req_out <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    core_ready <= 1'b1;
                    if (core_ready && core_valid) begin
                        core_ready <= 1'b0;
                        if (core_op == 2'b11) begin
                            state <= S_ERR;
                        end else begin
                            state               <= S_ISSUE;
                            op_q                <= core_op;
                            retry_cnt           <= '0;
                            req_valid_out       <= 1'b1;
                            addr_req_out        <= SYNC_BASE | {32'h0, core_idx, 2'b00};
                            data_req_out        <= {{(DEPTH-47){1'b0}}, core_addend, core_wdata};
                            id_req_out          <= CORE_ID;
                            packet_type_req_out <= (core_op == OP_WRITE) ? PT_WRITE :
                                                   (core_op == OP_FADD)  ? PT_FADD  : PT_READ;
                        end
                    end
                end
                S_ISSUE: begin
                    if (req_ready_in) begin
                        req_valid_out <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (match) begin
                        core_resp_valid <= 1'b1;
                        core_resp_data  <= data_resp_in[31:0];
                        core_resp_err   <= 1'b0;
                        state           <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt     <= retry_cnt + 1'b1;
                            req_valid_out <= 1'b1;
                            state         <= S_ISSUE;
                        end else begin
                            core_resp_valid <= 1'b1;
                            core_resp_data  <= 32'h0;
                            core_resp_err   <= 1'b1;
                            state           <= S_RESP;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    core_resp_valid <= 1'b1;
                    core_resp_data  <= 32'h0;
                    core_resp_err   <= 1'b1;
                    state           <= S_RESP;
                end
                S_RESP: begin
                    core_resp_valid <= 1'b0;
                    retry_cnt       <= '0;
                    core_ready      <= 1'b1;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_synch_req_unit.sv
// tb/tb_synch_req_unit.sv - directed self-checking bench for synch_req_unit
module tb_synch_req_unit;

    localparam int          DEPTH = 64;
    localparam logic [3:0]  CID   = 4'h5;
    localparam logic [35:0] BASE  = 36'h1_2345_6780;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             core_valid = 1'b0;
    logic             core_ready;
    logic [1:0]       core_op = 2'b00;
    logic [1:0]       core_idx = 2'b00;
    logic [31:0]      core_wdata = 32'h0;
    logic [14:0]      core_addend = 15'h0;
    logic             core_resp_valid;
    logic [31:0]      core_resp_data;
    logic             core_resp_err;
    logic             req_valid_out;
    logic             req_ready_in = 1'b0;
    logic [35:0]      addr_req_out;
    logic [DEPTH-1:0] data_req_out;
    logic [3:0]       id_req_out;
    logic [2:0]       packet_type_req_out;
    logic             resp_valid_in = 1'b0;
    logic [3:0]       id_resp_in = 4'h0;
    logic [2:0]       packet_type_resp_in = 3'b000;
    logic [DEPTH-1:0] data_resp_in = '0;

    int n_cmp = 0;
    int n_err = 0;

    synch_req_unit #(
        .DEPTH(DEPTH), .CORE_ID(CID), .SYNC_BASE(BASE), .TIMEOUT(4), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_ready(core_ready), .core_op(core_op),
        .core_idx(core_idx), .core_wdata(core_wdata), .core_addend(core_addend),
        .core_resp_valid(core_resp_valid), .core_resp_data(core_resp_data),
        .core_resp_err(core_resp_err),
        .req_valid_out(req_valid_out), .req_ready_in(req_ready_in),
        .addr_req_out(addr_req_out), .data_req_out(data_req_out),
        .id_req_out(id_req_out), .packet_type_req_out(packet_type_req_out),
        .resp_valid_in(resp_valid_in), .id_resp_in(id_resp_in),
        .packet_type_resp_in(packet_type_resp_in), .data_resp_in(data_resp_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [1:0] o, input logic [1:0] idx,
                      input logic [31:0] wd, input logic [14:0] ad);
        core_valid = 1'b1; core_op = o; core_idx = idx; core_wdata = wd; core_addend = ad;
    endtask

    task automatic resp(input logic v, input logic [3:0] id, input logic [2:0] pt,
                        input logic [63:0] d);
        resp_valid_in = v; id_resp_in = id; packet_type_resp_in = pt; data_resp_in = d;
    endtask

    initial begin
        int  issues;
        bit  got;
        logic [63:0] fa_data;

        // reset
        tick(); tick();
        chk("rst_core_ready", core_ready, 0);
        chk("rst_req_valid", req_valid_out, 0);
        chk("rst_resp_valid", core_resp_valid, 0);
        chk("rst_resp_data", core_resp_data, 0);
        chk("rst_id_req", id_req_out, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_core_ready", core_ready, 1);

        // read idx2, immediate response
        op(2'b00, 2'd2, 32'h0, 15'h0);
        tick();
        core_valid = 1'b0;
        chk("rd_req_valid_T1", req_valid_out, 1);
        chk("rd_core_ready_busy", core_ready, 0);
        chk("rd_addr", addr_req_out, 36'h1_2345_6788);
        chk("rd_type", packet_type_req_out, 3'b100);
        chk("rd_id", id_req_out, CID);
        req_ready_in = 1'b1;
        tick();
        req_ready_in = 1'b0;
        chk("rd_req_valid_wait", req_valid_out, 0);
        resp(1'b1, CID, 3'b110, 64'h1234);
        tick();
        resp(1'b0, 4'h0, 3'b000, 64'h0);
        chk("rd_resp_valid_T3", core_resp_valid, 1);
        chk("rd_resp_data", core_resp_data, 32'h1234);
        chk("rd_resp_err", core_resp_err, 0);
        tick();
        chk("rd_resp_pulse_end", core_resp_valid, 0);
        chk("rd_resp_data_hold", core_resp_data, 32'h1234);
        chk("rd_core_ready_back", core_ready, 1);

        // fetch-add idx1 with 5 stall cycles, then filtered responses
        fa_data = {17'h0, 15'h7FFF, 32'hDEADBEEF};
        op(2'b10, 2'd1, 32'hDEADBEEF, 15'h7FFF);
        tick();
        core_valid = 1'b0;
        core_wdata = 32'h0; core_addend = 15'h0; core_idx = 2'd0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fa_valid_%0d", i), req_valid_out, 1);
            chk($sformatf("fa_addr_%0d", i), addr_req_out, 36'h1_2345_6784);
            chk($sformatf("fa_data_%0d", i), data_req_out, fa_data);
            chk($sformatf("fa_type_%0d", i), packet_type_req_out, 3'b010);
            if (i == 5) req_ready_in = 1'b1;
            tick();
        end
        req_ready_in = 1'b0;
        chk("fa_req_valid_wait", req_valid_out, 0);
        resp(1'b1, CID ^ 4'h1, 3'b101, 64'h11);
        tick();
        chk("fa_bad_id_ignored", core_resp_valid, 0);
        resp(1'b1, CID, 3'b110, 64'h22);
        tick();
        chk("fa_bad_type_ignored", core_resp_valid, 0);
        chk("fa_no_reissue", req_valid_out, 0);
        resp(1'b1, CID, 3'b101, 64'h55);
        tick();
        resp(1'b0, 4'h0, 3'b000, 64'h0);
        chk("fa_resp_valid", core_resp_valid, 1);
        chk("fa_resp_data", core_resp_data, 32'h55);
        tick();

        // write idx3, ack returns old value; upper response bits ignored
        op(2'b01, 2'd3, 32'hCAFEF00D, 15'h0);
        tick();
        core_valid = 1'b0;
        chk("wr_addr", addr_req_out, 36'h1_2345_678C);
        chk("wr_type", packet_type_req_out, 3'b111);
        chk("wr_data", data_req_out, 64'h0000_0000_CAFE_F00D);
        req_ready_in = 1'b1;
        tick();
        req_ready_in = 1'b0;
        resp(1'b1, CID, 3'b101, 64'hFFFF_FFFF_0BAD_F00D);
        tick();
        resp(1'b0, 4'h0, 3'b000, 64'h0);
        chk("wr_resp_valid", core_resp_valid, 1);
        chk("wr_resp_data", core_resp_data, 32'h0BAD_F00D);
        chk("wr_resp_err", core_resp_err, 0);
        tick();

        // illegal op
        op(2'b11, 2'd0, 32'h0, 15'h0);
        tick();
        core_valid = 1'b0;
        chk("ill_no_req_T1", req_valid_out, 0);
        chk("ill_no_resp_T1", core_resp_valid, 0);
        chk("ill_core_ready_T1", core_ready, 0);
        tick();
        chk("ill_no_req_T2", req_valid_out, 0);
        chk("ill_resp_valid_T2", core_resp_valid, 1);
        chk("ill_resp_err", core_resp_err, 1);
        chk("ill_resp_data", core_resp_data, 0);
        tick();
        chk("ill_resp_end", core_resp_valid, 0);
        chk("ill_core_ready_back", core_ready, 1);

        // no response: 3 issues then error
        op(2'b00, 2'd0, 32'h0, 15'h0);
        tick();
        core_valid = 1'b0;
        req_ready_in = 1'b1;
        issues = 0;
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (req_valid_out && req_ready_in) issues++;
            if (core_resp_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        req_ready_in = 1'b0;
        chk("to_resp_seen", got, 1);
        chk("to_issue_count", issues, 3);
        chk("to_resp_err", core_resp_err, 1);
        chk("to_resp_data", core_resp_data, 0);
        tick();
        chk("to_core_ready_back", core_ready, 1);

        // reset during WAIT, then stale response
        op(2'b00, 2'd2, 32'h0, 15'h0);
        tick();
        core_valid = 1'b0;
        req_ready_in = 1'b1;
        tick();
        req_ready_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_core_ready", core_ready, 0);
        chk("mid_rst_resp_data", core_resp_data, 0);
        chk("mid_rst_resp_err", core_resp_err, 0);
        resp(1'b1, CID, 3'b110, 64'h99);
        tick();
        chk("stale_ignored_1", core_resp_valid, 0);
        chk("stale_core_ready", core_ready, 1);
        resp(1'b0, 4'h0, 3'b000, 64'h0);
        tick();
        chk("stale_ignored_2", core_resp_valid, 0);

        // fresh read completes normally
        op(2'b00, 2'd1, 32'h0, 15'h0);
        tick();
        core_valid = 1'b0;
        chk("new_rd_req_valid", req_valid_out, 1);
        chk("new_rd_addr", addr_req_out, 36'h1_2345_6784);
        req_ready_in = 1'b1;
        tick();
        req_ready_in = 1'b0;
        resp(1'b1, CID, 3'b110, 64'hABCD);
        tick();
        resp(1'b0, 4'h0, 3'b000, 64'h0);
        chk("new_rd_resp_valid", core_resp_valid, 1);
        chk("new_rd_resp_data", core_resp_data, 32'hABCD);
        tick();
        chk("new_rd_resp_end", core_resp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
